// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg: shared constants for the burst RAM arbiter.
// Command encodings, one-hot FSM states and default widths.
package burst_ram_pkg;

  localparam int DATA_BITWIDTH = 64;
  localparam int BURST_COUNT   = 4;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [3:0] {
    STATE_IDLE  = 4'b0001,
    STATE_WRITE = 4'b0010,
    STATE_READ  = 4'b0100,
    STATE_DONE  = 4'b1000
  } state_t;

endpackage

// File: rtl/burst_ram_arbiter_if.sv
// burst_ram_arbiter_if: command/data bus towards the burst RAM controller.
// master = arbiter side, slave = RAM side.
interface burst_ram_arbiter_if #(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int DATA_BITWIDTH  = burst_ram_pkg::DATA_BITWIDTH
);

  logic                       ram_cmd;
  logic                       ram_cmd_en;
  logic [DEPTH_BITWIDTH-1:0]  ram_addr;
  logic [DATA_BITWIDTH-1:0]   ram_wr_data;
  logic [DATA_BITWIDTH/8-1:0] ram_data_mask;
  logic [DATA_BITWIDTH-1:0]   ram_rd_data;
  logic                       ram_rd_data_ready;
  logic                       ram_busy;

  modport master (
    output ram_cmd, ram_cmd_en, ram_addr,
    output ram_wr_data, ram_data_mask,
    input  ram_rd_data, ram_rd_data_ready, ram_busy
  );

  modport slave (
    input  ram_cmd, ram_cmd_en, ram_addr,
    input  ram_wr_data, ram_data_mask,
    output ram_rd_data, ram_rd_data_ready, ram_busy
  );

endinterface

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: shares one burst RAM port between two line requesters.
// Define BURST_RAM_ARBITER_FIXED_PRIORITY_EN to give r0 fixed priority.
module burst_ram_arbiter
  import burst_ram_pkg::*;
#(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int DATA_BITWIDTH  = burst_ram_pkg::DATA_BITWIDTH,
  parameter int BURST_COUNT    = burst_ram_pkg::BURST_COUNT
) (
  input  logic clk,
  input  logic rst,

  input  logic                                r0_req,
  input  logic                                r0_cmd,
  input  logic [DEPTH_BITWIDTH-1:0]           r0_addr,
  input  logic [DATA_BITWIDTH*BURST_COUNT-1:0] r0_wr_line,
  output logic                                r0_done,

  input  logic                                r1_req,
  input  logic                                r1_cmd,
  input  logic [DEPTH_BITWIDTH-1:0]           r1_addr,
  input  logic [DATA_BITWIDTH*BURST_COUNT-1:0] r1_wr_line,
  output logic                                r1_done,

  output logic [DATA_BITWIDTH*BURST_COUNT-1:0] rd_line,

  burst_ram_arbiter_if.master ram
);

  localparam int LINE_W = DATA_BITWIDTH * BURST_COUNT;
  localparam int IDX_W  = $clog2(BURST_COUNT);
  localparam int CNT_W  = IDX_W + 1;

  state_t             state;
  logic               grant;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic               pick_r1;
  logic               grant_en;
  logic               win_cmd;
  logic [DEPTH_BITWIDTH-1:0] win_addr;
  logic [DATA_BITWIDTH-1:0]  win_word0;
  logic [LINE_W-1:0]  line_live;

`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
  assign pick_r1 = r1_req & ~r0_req;
`else
  logic last_grant;

  // On a tie the requester that was not served last wins.
  assign pick_r1 = r1_req & (~r0_req | ~last_grant);

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (grant_en)
      last_grant <= pick_r1;
  end
`endif

  assign grant_en  = (state == STATE_IDLE) & ~ram.ram_busy
                   & (r0_req | r1_req);
  assign win_cmd   = pick_r1 ? r1_cmd : r0_cmd;
  assign win_addr  = pick_r1 ? r1_addr : r0_addr;
  assign win_word0 = pick_r1 ? r1_wr_line[DATA_BITWIDTH-1:0]
                             : r0_wr_line[DATA_BITWIDTH-1:0];
  assign line_live = grant ? r1_wr_line : r0_wr_line;
  assign idx       = cnt[IDX_W-1:0];

  assign ram.ram_data_mask = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= STATE_IDLE;
      grant           <= 1'b0;
      cnt             <= '0;
      ram.ram_cmd     <= 1'b0;
      ram.ram_cmd_en  <= 1'b0;
      ram.ram_addr    <= '0;
      ram.ram_wr_data <= '0;
      rd_line         <= '0;
      r0_done         <= 1'b0;
      r1_done         <= 1'b0;
    end else begin
      ram.ram_cmd_en <= 1'b0;
      r0_done        <= 1'b0;
      r1_done        <= 1'b0;
      unique case (state)
        STATE_IDLE: begin
          if (grant_en) begin
            grant           <= pick_r1;
            ram.ram_cmd_en  <= 1'b1;
            ram.ram_cmd     <= win_cmd;
            ram.ram_addr    <= win_addr;
            ram.ram_wr_data <= win_word0;
            if (win_cmd == CMD_WRITE) begin
              cnt   <= CNT_W'(1);
              state <= STATE_WRITE;
            end else begin
              cnt   <= '0;
              state <= STATE_READ;
            end
          end
        end
        STATE_WRITE: begin
          if (cnt == CNT_W'(BURST_COUNT)) begin
            state   <= STATE_DONE;
            r0_done <= ~grant;
            r1_done <= grant;
          end else begin
            ram.ram_wr_data <=
              line_live[idx*DATA_BITWIDTH +: DATA_BITWIDTH];
            cnt <= cnt + 1'b1;
          end
        end
        STATE_READ: begin
          if (ram.ram_rd_data_ready) begin
            rd_line[idx*DATA_BITWIDTH +: DATA_BITWIDTH] <=
              ram.ram_rd_data;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(BURST_COUNT - 1)) begin
              state   <= STATE_DONE;
              r0_done <= ~grant;
              r1_done <= grant;
            end
          end
        end
        STATE_DONE: state <= STATE_IDLE;
        default:    state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: vector table plus tie, priority and reset sequences
// against a behavioural burst RAM with calibration busy and read delay.
module tb_burst_ram_arbiter;
  import burst_ram_pkg::*;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int BC = 4;
  localparam int LW = DW * BC;
  localparam int CAL = 10;
  localparam int RD_DELAY = 8;

  localparam logic [LW-1:0] LINE_A =
    {64'h44, 64'h33, 64'h22, 64'h11};
  localparam logic [LW-1:0] LINE_B =
    {64'hD4, 64'hC3, 64'hB2, 64'hA1};

  typedef struct packed {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
  } txn_t;

  typedef struct {
    bit            who;
    logic          cmd;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
    logic [LW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          r0_req = 1'b0, r0_cmd = 1'b0;
  logic          r1_req = 1'b0, r1_cmd = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [LW-1:0] r0_wr_line = '0, r1_wr_line = '0;
  logic          r0_done, r1_done;
  logic [LW-1:0] rd_line;

  burst_ram_arbiter_if #(.DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW)) ram_bus();

  burst_ram_arbiter #(
    .DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW), .BURST_COUNT(BC)
  ) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_cmd(r0_cmd), .r0_addr(r0_addr),
    .r0_wr_line(r0_wr_line), .r0_done(r0_done),
    .r1_req(r1_req), .r1_cmd(r1_cmd), .r1_addr(r1_addr),
    .r1_wr_line(r1_wr_line), .r1_done(r1_done),
    .rd_line(rd_line),
    .ram(ram_bus)
  );

  int checks = 0;
  int failures = 0;
  txn_t q0[$];
  txn_t q1[$];
  bit exp_order[$];
  int r0_again = 0;

  task automatic check(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input logic [LW-1:0] act);
    checks++;
    failures++;
    $display("FAIL %s act=%0h exp=none", name, act);
  endtask

  // Behavioural RAM and output monitor, both on the falling edge.
  logic [DW-1:0] mem [16];
  bit  mem_init = 0;
  int  tick = 0, cal = 0, beat = 0, dly = 0, mode = 0;
  int  last_beat_tick = 0, cur_tick = 0, wr_n = 0;
  logic [AW-1:0] burst_addr = '0;
  logic          cur_cmd = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [LW-1:0] wr_seen = '0;
  bit            done_prev = 0;

  task automatic on_done();
    txn_t t;
    bit who;
    who = r1_done;
    check("done_onehot", LW'(r0_done & r1_done), '0);
    if (exp_order.size() == 0) begin
      bad("unexpected_done", LW'(who));
      return;
    end
    check("grant_order", LW'(who), LW'(exp_order.pop_front()));
    if ((who ? q1.size() : q0.size()) == 0) begin
      bad("unexpected_done_q", LW'(who));
      return;
    end
    if (who) t = q1.pop_front();
    else     t = q0.pop_front();
    check("cmd", LW'(cur_cmd), LW'(t.cmd));
    check("addr", LW'(cur_addr), LW'(t.addr));
    if (t.cmd == CMD_WRITE) begin
      check("wr_latency", LW'(tick - cur_tick), LW'(BC));
      check("wr_words", wr_seen, t.line);
    end else begin
      check("rd_latency", LW'(tick - last_beat_tick), LW'(1));
      check("rd_line", rd_line, t.line);
    end
  endtask

  task automatic monitor();
    if (ram_bus.ram_cmd_en) begin
      check("no_grant_while_busy", LW'(ram_bus.ram_busy), '0);
      cur_cmd  = ram_bus.ram_cmd;
      cur_addr = ram_bus.ram_addr;
      cur_tick = tick;
      if (ram_bus.ram_cmd == CMD_WRITE) begin
        wr_seen[DW-1:0] = ram_bus.ram_wr_data;
        wr_n = 1;
      end
    end else if (wr_n > 0 && wr_n < BC) begin
      wr_seen[wr_n*DW +: DW] = ram_bus.ram_wr_data;
      wr_n++;
    end
    if (done_prev)
      check("done_one_cycle", LW'(r0_done | r1_done), '0);
    if (r0_done | r1_done) on_done();
    done_prev = r0_done | r1_done;
  endtask

  always @(negedge clk) begin
    tick++;
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] = 64'h1000 + 64'(i);
      mem_init = 1;
    end
    if (rst) begin
      wr_n = 0;
      done_prev = 0;
    end else begin
      monitor();
    end
    ram_bus.ram_rd_data_ready = 1'b0;
    if (rst) begin
      ram_bus.ram_busy = 1'b1;
      ram_bus.ram_rd_data = '0;
      cal = CAL;
      mode = 0;
    end else begin
      case (mode)
        0: begin
          if (ram_bus.ram_cmd_en) begin
            burst_addr = ram_bus.ram_addr;
            ram_bus.ram_busy = 1'b1;
            if (ram_bus.ram_cmd == CMD_WRITE) begin
              mem[burst_addr] = ram_bus.ram_wr_data;
              beat = 1;
              mode = 1;
            end else begin
              beat = 0;
              dly = RD_DELAY;
              mode = 2;
            end
          end else if (cal > 0) begin
            cal--;
            if (cal == 0) ram_bus.ram_busy = 1'b0;
          end
        end
        1: begin
          mem[AW'(burst_addr + AW'(beat))] = ram_bus.ram_wr_data;
          beat++;
          if (beat == BC) begin
            mode = 0;
            ram_bus.ram_busy = 1'b0;
          end
        end
        default: begin
          if (dly > 0) begin
            dly--;
          end else if (beat < BC) begin
            ram_bus.ram_rd_data_ready = 1'b1;
            ram_bus.ram_rd_data = mem[AW'(burst_addr + AW'(beat))];
            beat++;
            if (beat == BC) last_beat_tick = tick;
          end else begin
            mode = 0;
            ram_bus.ram_busy = 1'b0;
          end
        end
      endcase
    end
  end

  task automatic raise(input bit who, input logic cmd,
                       input logic [AW-1:0] addr,
                       input logic [LW-1:0] line,
                       input logic [LW-1:0] exp);
    txn_t t;
    t.cmd = cmd;
    t.addr = addr;
    t.line = exp;
    if (who) begin
      r1_req = 1'b1; r1_cmd = cmd; r1_addr = addr; r1_wr_line = line;
      q1.push_back(t);
    end else begin
      r0_req = 1'b1; r0_cmd = cmd; r0_addr = addr; r0_wr_line = line;
      q0.push_back(t);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    #1;
    if (r0_done) r0_req = 1'b0;
    else if (!r0_req && r0_again > 0) begin
      r0_again--;
      raise(1'b0, CMD_READ, 4'd4, '0, LINE_A);
    end
    if (r1_done) r1_req = 1'b0;
  endtask

  function automatic bit quiet();
    return q0.size() == 0 && q1.size() == 0 && exp_order.size() == 0
        && !r0_req && !r1_req && r0_again == 0;
  endfunction

  task automatic run_until_quiet(input string name, input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!quiet() && n < budget);
    checks++;
    if (!quiet()) begin
      failures++;
      $display("FAIL timeout_%s act=%0d exp=quiet", name, n);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_cmd_en"}, LW'(ram_bus.ram_cmd_en), '0);
    check({name, "_cmd"}, LW'(ram_bus.ram_cmd), '0);
    check({name, "_addr"}, LW'(ram_bus.ram_addr), '0);
    check({name, "_wr_data"}, LW'(ram_bus.ram_wr_data), '0);
    check({name, "_mask"}, LW'(ram_bus.ram_data_mask), '0);
    check({name, "_rd_line"}, rd_line, '0);
    check({name, "_done"}, LW'({r0_done, r1_done}), '0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, CMD_WRITE, 4'd4,  LINE_A, LINE_A};
    vecs[1] = '{1'b0, CMD_READ,  4'd4,  '0,     LINE_A};
    vecs[2] = '{1'b1, CMD_WRITE, 4'd14, LINE_B, LINE_B};
    vecs[3] = '{1'b1, CMD_READ,  4'd14, '0,     LINE_B};
    vecs[4] = '{1'b0, CMD_READ,  4'd0,  '0,
                {64'h1003, 64'h1002, 64'hD4, 64'hC3}};
    vecs[5] = '{1'b1, CMD_READ,  4'd15, '0,
                {64'h1002, 64'hD4, 64'hC3, 64'hB2}};

    repeat (3) cycle();
    check_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      exp_order.push_back(vecs[i].who);
      raise(vecs[i].who, vecs[i].cmd, vecs[i].addr,
            vecs[i].line, vecs[i].exp);
      run_until_quiet("vec", 200);
    end

    for (int k = 0; k < 3; k++) begin
      exp_order.push_back(1'b0);
      exp_order.push_back(1'b1);
      raise(1'b0, CMD_READ, 4'd4, '0, LINE_A);
      raise(1'b1, CMD_READ, 4'd14, '0, LINE_B);
      run_until_quiet("tie", 300);
    end

`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
    exp_order.push_back(1'b0);
    exp_order.push_back(1'b0);
    exp_order.push_back(1'b0);
    exp_order.push_back(1'b1);
`else
    exp_order.push_back(1'b0);
    exp_order.push_back(1'b1);
    exp_order.push_back(1'b0);
    exp_order.push_back(1'b0);
`endif
    r0_again = 2;
    raise(1'b0, CMD_READ, 4'd4, '0, LINE_A);
    raise(1'b1, CMD_READ, 4'd14, '0, LINE_B);
    run_until_quiet("rerequest", 500);

    exp_order.push_back(1'b0);
    raise(1'b0, CMD_READ, 4'd4, '0, LINE_A);
    begin
      int n = 0;
      while (!(ram_bus.ram_rd_data_ready && beat == 2) && n < 100) begin
        cycle();
        n++;
      end
      checks++;
      if (n >= 100) begin
        failures++;
        $display("FAIL wait_second_beat act=%0d exp=beat2", n);
      end
    end
    rst = 1'b1;
    r0_req = 1'b0;
    q0.delete();
    q1.delete();
    exp_order.delete();
    cycle();
    check_zero("midrst");
    rst = 1'b0;
    repeat (6) cycle();
    check("midrst_no_done", LW'(q0.size() + q1.size()), '0);

    exp_order.push_back(1'b0);
    raise(1'b0, CMD_READ, 4'd14, '0, LINE_B);
    run_until_quiet("after_rst", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
